// File: rtl/perceptron_ctrl.sv
// perceptron_ctrl: UART packet framer and command executor for a dot-product
// datapath. Collects 6-byte packets (address, command, 4 payload bytes),
// decodes commands addressed to this node, pulses the datapath strobes and
// streams the 32-bit accumulator back out, LSB first.
module perceptron_ctrl #(
    parameter int NODE_ADDR = 100,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        a_we,
    output logic        b_we,
    output logic [31:0] vec,
    output logic        op_mul,
    output logic        op_acc,
    input  logic        dp_busy,
    input  logic [31:0] result,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        drop
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The counter discards the partial packet on the idle cycle that brings it to TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_SEND  = 2'd3;

    logic [2:0]    r_byte_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_pkt_done;
    logic [7:0]    r_addr;
    logic [7:0]    r_cmd;
    logic [31:0]   r_payload;
    logic [3:0]    w_lane_we;
    logic          w_pkt_hit;

    logic [1:0]    r_state;
    logic [1:0]    r_byte_idx;
    logic [1:0]    w_idx_next;
    logic [31:0]   r_shadow;
    logic          r_a_we;
    logic          r_b_we;
    logic          r_op_mul;
    logic          r_op_acc;
    logic [31:0]   r_vec;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;
    logic          r_drop;

    // Payload byte lane write enables: packet byte 2 lands in lane 0, byte 5 in lane 3.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_we[gi] = rx_valid && (r_byte_cnt == 3'(gi + 2));
        end
    endgenerate

    assign w_pkt_hit  = r_pkt_done && (r_addr == 8'(NODE_ADDR));
    assign w_idx_next = r_byte_idx + 2'd1;

    // Byte position tracking, packet-complete strobe and inter-byte timeout.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_byte_cnt <= 3'd0;
            r_tmo_cnt  <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (rx_valid) begin
                r_tmo_cnt <= '0;
                if (r_byte_cnt == 3'd5) begin
                    r_byte_cnt <= 3'd0;
                    r_pkt_done <= 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 3'd1;
                end
            end else if (r_byte_cnt != 3'd0) begin
                if (r_tmo_cnt == TMO_LAST) begin
                    r_byte_cnt <= 3'd0;
                    r_tmo_cnt  <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + TW'(1);
                end
            end
        end
    end

    // Capture header and payload bytes into their slots as they arrive.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_addr    <= 8'd0;
            r_cmd     <= 8'd0;
            r_payload <= 32'd0;
        end else begin
            if (rx_valid && r_byte_cnt == 3'd0) r_addr <= rx_data;
            if (rx_valid && r_byte_cnt == 3'd1) r_cmd  <= rx_data;
            for (int i = 0; i < 4; i++) begin
                if (w_lane_we[i]) r_payload[8*i +: 8] <= rx_data;
            end
        end
    end

    // Command executor: issues strobes, waits on the datapath, streams the result.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state    <= S_IDLE;
            r_byte_idx <= 2'd0;
            r_shadow   <= 32'd0;
            r_a_we     <= 1'b0;
            r_b_we     <= 1'b0;
            r_op_mul   <= 1'b0;
            r_op_acc   <= 1'b0;
            r_vec      <= 32'd0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_drop     <= 1'b0;
        end else begin
            r_a_we   <= 1'b0;
            r_b_we   <= 1'b0;
            r_op_mul <= 1'b0;
            r_op_acc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pkt_hit) begin
                        case (r_cmd)
                            8'd0: begin
                                r_a_we  <= 1'b1;
                                r_vec   <= r_payload;
                                r_state <= S_ISSUE;
                            end
                            8'd1: begin
                                r_b_we  <= 1'b1;
                                r_vec   <= r_payload;
                                r_state <= S_ISSUE;
                            end
                            8'd5: begin
                                r_op_mul <= 1'b1;
                                r_state  <= S_ISSUE;
                            end
                            8'd6: begin
                                r_op_acc <= 1'b1;
                                r_state  <= S_ISSUE;
                            end
                            8'd2: begin
                                r_shadow   <= result;
                                r_tx_data  <= result[7:0];
                                r_tx_valid <= 1'b1;
                                r_byte_idx <= 2'd0;
                                r_state    <= S_SEND;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    // Strobe cycle; arithmetic ops must then see the datapath finish.
                    r_state <= (r_op_mul || r_op_acc) ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (!dp_busy) r_state <= S_IDLE;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (r_byte_idx == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_byte_idx <= 2'd0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_byte_idx <= w_idx_next;
                            r_tx_data  <= r_shadow[{w_idx_next, 3'b000} +: 8];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A packet for us that arrives while busy cannot be executed.
            if (w_pkt_hit && r_state != S_IDLE) r_drop <= 1'b1;
        end
    end

    assign a_we     = r_a_we;
    assign b_we     = r_b_we;
    assign op_mul   = r_op_mul;
    assign op_acc   = r_op_acc;
    assign vec      = r_vec;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign drop     = r_drop;

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Testbench for perceptron_ctrl: directed table, corner-case sequences and
// randomized packets checked against an event-level reference model.
module tb_perceptron_ctrl;

    localparam int NODE = 100;
    localparam int TMO  = 20;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        a_we, b_we, op_mul, op_acc, tx_valid, drop;
    logic [31:0] vec;
    logic [7:0]  tx_data;
    logic        dp_busy = 1'b0;
    logic [31:0] result = 32'd0;
    logic        tx_ready = 1'b1;

    perceptron_ctrl #(.NODE_ADDR(NODE), .TIMEOUT(TMO)) dut (
        .clk(clk), .nRst(nRst), .rx_valid(rx_valid), .rx_data(rx_data),
        .a_we(a_we), .b_we(b_we), .vec(vec), .op_mul(op_mul), .op_acc(op_acc),
        .dp_busy(dp_busy), .result(result), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Dot product of the four unsigned byte lanes.
    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = 32'd0;
        for (int k = 0; k < 4; k++) s = s + 32'(a[8*k +: 8]) * 32'(b[8*k +: 8]);
        return s;
    endfunction

    // Datapath stand-in: three busy cycles per op, then the accumulator updates.
    logic [31:0] dp_a = 32'd0, dp_b = 32'd0;
    int          busy_cnt = 0;
    logic        pend_acc = 1'b0;
    always @(posedge clk) begin
        if (a_we) dp_a <= vec;
        if (b_we) dp_b <= vec;
        if (op_mul || op_acc) begin
            busy_cnt <= 3;
            pend_acc <= op_acc;
            dp_busy  <= 1'b1;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            dp_busy  <= 1'b0;
            result   <= pend_acc ? result + dot(dp_a, dp_b) : dot(dp_a, dp_b);
        end
    end

    // Transmitter readiness: 0 always ready, 1 stalled, 2 random.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'b0;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Expected observable events: kind 0 a_we, 1 b_we, 2 op_mul, 3 op_acc, 4 tx word.
    typedef struct {
        int          kind;
        logic [31:0] val;
        int          at;
    } ev_t;
    ev_t exq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic take_ev(input int k, input logic [31:0] act_vec, output logic [31:0] word);
        ev_t e;
        word = 32'd0;
        if (exq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d required none (cycle %0d)", k, cyc);
        end else begin
            e = exq.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            chk("event_cycle", 32'(cyc), 32'(e.at));
            if (e.kind < 2) chk("vec", act_vec, e.val);
            word = e.val;
        end
    endtask

    // Output monitor: strobes, one-hot, tx byte order and tx_valid holding.
    logic        tx_act = 1'b0;
    int          tx_idx = 0;
    logic [31:0] tx_word = 32'd0;
    logic [31:0] junk;
    int          nstb;
    always @(negedge clk) begin
        if (!nRst) begin
            exq.delete();
            tx_act = 1'b0;
            tx_idx = 0;
        end else begin
            nstb = int'(a_we) + int'(b_we) + int'(op_mul) + int'(op_acc);
            if (nstb > 1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL strobe_onehot: got %0d strobes high required at most 1", nstb);
            end else if (nstb == 1) begin
                take_ev(a_we ? 0 : b_we ? 1 : op_mul ? 2 : 3, vec, junk);
            end
            if (tx_valid) begin
                if (!tx_act) begin
                    take_ev(4, 32'd0, tx_word);
                    tx_act = 1'b1;
                    tx_idx = 0;
                end
                chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_word[8*tx_idx +: 8]});
                if (tx_ready) begin
                    tx_idx++;
                    if (tx_idx == 4) tx_act = 1'b0;
                end
            end else if (tx_act) begin
                n_cmp++;
                n_fail++;
                $display("FAIL tx_valid_hold: got 0 required 1 at byte %0d", tx_idx);
                tx_act = 1'b0;
            end
        end
    end

    function automatic void expect_ev(input int k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        e.at   = cyc + 1;
        exq.push_back(e);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] addr, input logic [7:0] cmd,
                            input logic [31:0] pay, input int maxgap);
        send_byte(addr, $urandom_range(0, maxgap));
        send_byte(cmd, $urandom_range(0, maxgap));
        for (int k = 0; k < 4; k++) send_byte(pay[8*k +: 8], (k == 3) ? 0 : $urandom_range(0, maxgap));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #2;
            t++;
        end while ((exq.size() != 0 || dp_busy || tx_valid) && t < 400);
        if (t >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_wait: got %0d pending events required 0 within 400 cycles", exq.size());
            exq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_a_we", 32'(a_we), 32'd0);
        chk("rst_b_we", 32'(b_we), 32'd0);
        chk("rst_op_mul", 32'(op_mul), 32'd0);
        chk("rst_op_acc", 32'(op_acc), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_vec", vec, 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  cmd;
        logic [31:0] pay;
        int          kind;
        logic [31:0] val;
        int          stall;
    } tv_t;
    tv_t tab[10];

    logic [31:0] m_a, m_b, m_r;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish required finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  addr, cmd;
        logic [31:0] pay;
        int          sel;

        tab[0] = '{8'd100, 8'd0, 32'h04030201,  0, 32'h04030201,  0};
        tab[1] = '{8'd100, 8'd0, 32'h03030303,  0, 32'h03030303,  0};
        tab[2] = '{8'd100, 8'd1, 32'h281E140A,  1, 32'h281E140A,  0};
        tab[3] = '{8'd100, 8'd5, 32'h00000000,  2, 32'h00000000,  0};
        tab[4] = '{8'd100, 8'd2, 32'h00000000,  4, 32'h0000012C, 10};
        tab[5] = '{8'd101, 8'd5, 32'h00000000, -1, 32'h00000000,  0};
        tab[6] = '{8'd100, 8'd7, 32'hDEADBEEF, -1, 32'h00000000,  0};
        tab[7] = '{8'd100, 8'd0, 32'h11223344,  0, 32'h11223344,  0};
        tab[8] = '{8'd100, 8'd6, 32'h00000000,  3, 32'h00000000,  0};
        tab[9] = '{8'd100, 8'd2, 32'h00000000,  4, 32'h00000E74,  0};

        nRst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        nRst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors.
        for (int i = 0; i < 10; i++) begin
            if (tab[i].stall > 0) rdy_mode = 1;
            send_pkt(tab[i].addr, tab[i].cmd, tab[i].pay, 0);
            if (tab[i].kind >= 0) expect_ev(tab[i].kind, tab[i].val);
            repeat (tab[i].stall) @(posedge clk);
            #1;
            rdy_mode = 0;
            wait_idle();
        end
        chk("drop_after_table", 32'(drop), 32'd0);

        // Randomized packets against the event-level model.
        m_a = 32'h11223344;
        m_b = 32'h281E140A;
        m_r = 32'h00000E74;
        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(1, 5);
                for (int k = 0; k < sel; k++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 3));
                repeat (TMO + 2) @(posedge clk);
                #1;
            end
            addr = ($urandom_range(0, 3) != 0) ? 8'(NODE) : 8'($urandom_range(0, 255));
            if (n % 7 == 3 && addr == 8'(NODE)) addr = 8'd101;
            sel = $urandom_range(0, 5);
            case (sel)
                0: cmd = 8'd0;
                1: cmd = 8'd1;
                2: cmd = 8'd2;
                3: cmd = 8'd5;
                4: cmd = 8'd6;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            pay = $urandom;
            send_pkt(addr, cmd, pay, 3);
            if (addr == 8'(NODE)) begin
                case (cmd)
                    8'd0: begin m_a = pay; expect_ev(0, pay); end
                    8'd1: begin m_b = pay; expect_ev(1, pay); end
                    8'd5: begin m_r = dot(m_a, m_b); expect_ev(2, 32'd0); end
                    8'd6: begin m_r = m_r + dot(m_a, m_b); expect_ev(3, 32'd0); end
                    8'd2: expect_ev(4, m_r);
                    default: ;
                endcase
            end
            wait_idle();
        end
        rdy_mode = 0;
        chk("drop_after_random", 32'(drop), 32'd0);

        // Partial packet abandoned by the inter-byte timeout.
        send_byte(8'd100, 0);
        send_byte(8'd0, 0);
        send_byte(8'd9, 0);
        repeat (TMO + 1) @(posedge clk);
        #1;
        send_pkt(8'd100, 8'd0, 32'h08070605, 0);
        expect_ev(0, 32'h08070605);
        wait_idle();

        // Addressed packet while SEND is stalled is dropped.
        rdy_mode = 1;
        send_pkt(8'd100, 8'd2, 32'd0, 0);
        expect_ev(4, m_r);
        send_pkt(8'd100, 8'd0, 32'hAABBCCDD, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_set", 32'(drop), 32'd1);
        rdy_mode = 0;
        wait_idle();
        chk("drop_sticky", 32'(drop), 32'd1);

        // Reset in the middle of a packet.
        send_byte(8'd100, 0);
        send_byte(8'd0, 0);
        send_byte(8'h55, 0);
        nRst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals();
        nRst = 1'b1;
        send_pkt(8'd100, 8'd1, 32'h0A0B0C0D, 0);
        expect_ev(1, 32'h0A0B0C0D);
        wait_idle();

        // Reset in the middle of a stalled SEND.
        rdy_mode = 1;
        send_pkt(8'd100, 8'd2, 32'd0, 0);
        expect_ev(4, m_r);
        repeat (4) @(posedge clk);
        #1;
        send_byte(8'd100, 0);
        send_byte(8'd1, 0);
        nRst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals();
        nRst = 1'b1;
        rdy_mode = 0;
        send_pkt(8'd100, 8'd0, 32'h12345678, 0);
        expect_ev(0, 32'h12345678);
        wait_idle();
        chk("final_drop", 32'(drop), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
